// File: rtl/loop_add_4_pipeline.sv
// loop_add_4_pipeline: 5-stage, II=1 kernel for
//   for i in 0..TRIP_COUNT-1: mem[DST_BASE+i] = mem[SRC_BASE+i] + ADDEND
// It talks to an external RAM through one combinational-read port and one
// synchronous-write port.
// Optional macro LOOP_ADD_4_PIPELINE_STATE_DBG_EN: when it is defined, the
// controller state codes (0 / 200000 / 6) appear on global_state_dbg. When it
// is undefined, global_state_dbg is tied to zero and the state register uses
// the minimum width.
module loop_add_4_pipeline #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TRIP_COUNT = 2,
    parameter int unsigned SRC_BASE   = 10,
    parameter int unsigned DST_BASE   = 0,
    parameter int unsigned ADDEND     = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              valid,
    output logic [ADDR_W-1:0] raddr_0,
    input  logic [DATA_W-1:0] rdata_0,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
    output logic              wen_0,
    output logic [31:0]       global_state_dbg
);

    // Issue counter must be able to hold TRIP_COUNT itself
    localparam int unsigned CNT_W = (TRIP_COUNT < 1) ? 1 : $clog2(TRIP_COUNT + 1);

`ifdef LOOP_ADD_4_PIPELINE_STATE_DBG_EN
    typedef enum logic [31:0] {
        IDLE = 32'd0,
        PIPE = 32'd200000,
        DONE = 32'd6
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PIPE,
        DONE
    } state_t;
`endif

    state_t              state;
    logic [CNT_W-1:0]    issued;
    logic                issue_done;
    logic                s1_v, s2_v, s3_v, s4_v;
    logic [ADDR_W-1:0]   s1_dst, s2_dst, s3_dst, s4_dst;
    logic [DATA_W-1:0]   s2_data, s3_data, s4_data;

    // All iterations have entered S1
    assign issue_done = (issued == CNT_W'(TRIP_COUNT));

`ifdef LOOP_ADD_4_PIPELINE_STATE_DBG_EN
    // Expose the controller state code
    assign global_state_dbg = 32'(state);
`else
    // Debug port unused in this build
    assign global_state_dbg = 32'd0;
`endif

    // Controller, issue logic and the free-running pipeline stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            issued  <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            s4_v    <= 1'b0;
            s1_dst  <= '0;
            s2_dst  <= '0;
            s3_dst  <= '0;
            s4_dst  <= '0;
            s2_data <= '0;
            s3_data <= '0;
            s4_data <= '0;
            raddr_0 <= '0;
            waddr_0 <= '0;
            wdata_0 <= '0;
            wen_0   <= 1'b0;
        end else begin
            // Stages advance every cycle; there are no stalls
            s1_v    <= 1'b0;
            s2_v    <= s1_v;
            s2_dst  <= s1_dst;
            s2_data <= rdata_0;
            s3_v    <= s2_v;
            s3_dst  <= s2_dst;
            s3_data <= s2_data + DATA_W'(ADDEND);
            s4_v    <= s3_v;
            s4_dst  <= s3_dst;
            s4_data <= s3_data;
            wen_0   <= s4_v;
            if (s4_v) begin
                waddr_0 <= s4_dst;
                wdata_0 <= s4_data;
            end

            // An iteration issues into S1 in IDLE or PIPE until all are issued
            if ((state != DONE) && !issue_done) begin
                s1_v    <= 1'b1;
                raddr_0 <= ADDR_W'(SRC_BASE) + ADDR_W'(issued);
                s1_dst  <= ADDR_W'(DST_BASE) + ADDR_W'(issued);
                issued  <= issued + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (TRIP_COUNT == 0) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        state <= PIPE;
                    end
                end
                PIPE: begin
                    // The last write commits at this edge when nothing remains behind it
                    if (wen_0 && issue_done && !(s1_v || s2_v || s3_v || s4_v)) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end
                end
                DONE: begin
                    valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_add_4_pipeline.sv
// Bench for loop_add_4_pipeline: a behavioural RAM, directed steps and a
// write scoreboard of expected (address, data) pairs.
module tb_loop_add_4_pipeline;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  raddr_0;
    logic [31:0] rdata_0;
    logic [4:0]  waddr_0;
    logic [31:0] wdata_0;
    logic        wen_0;
    logic [31:0] global_state_dbg;

    logic [31:0] mem [32];
    logic [36:0] exp_q [$];
    int          vectors;
    int          errors;

`ifdef LOOP_ADD_4_PIPELINE_STATE_DBG_EN
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_PIPE = 32'd200000;
    localparam logic [31:0] ST_DONE = 32'd6;
`else
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_PIPE = 32'd0;
    localparam logic [31:0] ST_DONE = 32'd0;
`endif

    loop_add_4_pipeline dut (
        .clk              (clk),
        .rst              (rst),
        .valid            (valid),
        .raddr_0          (raddr_0),
        .rdata_0          (rdata_0),
        .waddr_0          (waddr_0),
        .wdata_0          (wdata_0),
        .wen_0            (wen_0),
        .global_state_dbg (global_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational read, write committed at the rising edge
    assign rdata_0 = mem[raddr_0];
    always @(posedge clk) begin
        if (wen_0) mem[waddr_0] <= wdata_0;
    end

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write seen on the port must match the queue head
    always @(negedge clk) begin
        if (wen_0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {waddr_0, wdata_0}, 37'h1F_FFFF_FFFF);
            end else begin
                check("sb_write", {waddr_0, wdata_0}, exp_q.pop_front());
            end
        end
    end

    task automatic run_to_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 37'(n), 37'd7);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        mem[10] <= 32'd10;
        mem[11] <= 32'd5;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_state", 37'(global_state_dbg), 37'(ST_IDLE));
            check("rst_valid", 37'(valid), 37'd0);
            check("rst_wen",   37'(wen_0), 37'd0);
        end

        // First run: mem[0]=10+4, mem[1]=5+4
        exp_q.push_back({5'd0, 32'd14});
        exp_q.push_back({5'd1, 32'd9});
        rst = 1'b0;
        tick();
        check("e1_state", 37'(global_state_dbg), 37'(ST_PIPE));
        check("e1_raddr", 37'(raddr_0), 37'd10);
        tick();
        check("e2_valid", 37'(valid), 37'd0);
        check("e2_raddr", 37'(raddr_0), 37'd11);
        tick();
        tick();
        tick();
        check("e5_valid", 37'(valid), 37'd0);
        check("e5_write", {4'd0, wen_0, waddr_0, wdata_0}, {4'd0, 1'b1, 5'd0, 32'd14});
        tick();
        check("e6_valid", 37'(valid), 37'd0);
        check("e6_write", {4'd0, wen_0, waddr_0, wdata_0}, {4'd0, 1'b1, 5'd1, 32'd9});
        check("e6_mem0", 37'(mem[0]), 37'd14);
        tick();
        check("e7_state", 37'(global_state_dbg), 37'(ST_DONE));
        check("e7_valid", 37'(valid), 37'd1);
        check("e7_mem0", 37'(mem[0]), 37'd14);
        check("e7_mem1", 37'(mem[1]), 37'd9);
        tick();
        check("e8_valid", 37'(valid), 37'd1);
        check("e8_wen",   37'(wen_0), 37'd0);
        check("e8_mem1",  37'(mem[1]), 37'd9);
        check("run1_sb_empty", 37'(exp_q.size()), 37'd0);

        // Wrap-around: 0xFFFFFFFE + 4 = 2
        rst = 1'b1;
        mem[10] <= 32'hFFFF_FFFE;
        mem[0]  <= 32'd0;
        mem[1]  <= 32'd0;
        tick();
        check("wrap_rst_valid", 37'(valid), 37'd0);
        exp_q.push_back({5'd0, 32'd2});
        exp_q.push_back({5'd1, 32'd9});
        rst = 1'b0;
        run_to_valid("wrap_latency");
        check("wrap_mem0", 37'(mem[0]), 37'd2);
        check("wrap_mem1", 37'(mem[1]), 37'd9);
        check("wrap_sb_empty", 37'(exp_q.size()), 37'd0);

        // Reset in mid-PIPE: no writes may occur, then a clean rerun
        rst = 1'b1;
        mem[10] <= 32'd10;
        mem[0]  <= 32'd0;
        mem[1]  <= 32'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_state", 37'(global_state_dbg), 37'(ST_PIPE));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_rst_state", 37'(global_state_dbg), 37'(ST_IDLE));
            check("abort_rst_wen",   37'(wen_0), 37'd0);
        end
        check("abort_mem0", 37'(mem[0]), 37'd0);
        check("abort_mem1", 37'(mem[1]), 37'd0);
        exp_q.push_back({5'd0, 32'd14});
        exp_q.push_back({5'd1, 32'd9});
        rst = 1'b0;
        run_to_valid("rerun_latency");
        check("rerun_state", 37'(global_state_dbg), 37'(ST_DONE));
        check("rerun_mem0", 37'(mem[0]), 37'd14);
        check("rerun_mem1", 37'(mem[1]), 37'd9);
        check("rerun_sb_empty", 37'(exp_q.size()), 37'd0);
        tick();
        check("rerun_hold_valid", 37'(valid), 37'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
